// File: rtl/uart_pkg.sv
// Shared constants and types for the 8N1 UART byte receiver.
package uart_pkg;

    // Frame format: 8 data bits, 16x oversampling, majority of three mid-bit samples
    localparam int         DATA_BITS  = 8;
    localparam int         OVERSAMPLE = 16;
    localparam logic [3:0] SAMPLE_T0  = 4'd6;
    localparam logic [3:0] SAMPLE_T1  = 4'd7;
    localparam logic [3:0] SAMPLE_T2  = 4'd8;

    // Oversample divisors for a 50 MHz clock; tick period is divisor+1 clocks
    localparam logic [15:0] OS_DR_9600   = 16'd324;
    localparam logic [15:0] OS_DR_19200  = 16'd162;
    localparam logic [15:0] OS_DR_38400  = 16'd80;
    localparam logic [15:0] OS_DR_57600  = 16'd53;
    localparam logic [15:0] OS_DR_115200 = 16'd26;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

    // Rate select to oversample divisor; unused codes fall back to 9600
    function automatic logic [15:0] os_divisor(input logic [2:0] baud_set);
        case (baud_set)
            3'd0:    return OS_DR_9600;
            3'd1:    return OS_DR_19200;
            3'd2:    return OS_DR_38400;
            3'd3:    return OS_DR_57600;
            3'd4:    return OS_DR_115200;
            default: return OS_DR_9600;
        endcase
    endfunction

    // Two-out-of-three vote over the mid-bit samples
    function automatic logic majority3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/uart_rx_tick_gen.sv
// Oversample tick generator: one-cycle tick every divisor+1 clocks while enabled.
module uart_rx_tick_gen
    import uart_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [15:0] divisor,
    output logic        tick
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // Count 0..divisor, hold at zero while disabled so a new frame starts phase-aligned
    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (!enable) begin
            cnt_d = 16'd0;
        end else if (cnt_q == divisor) begin
            cnt_d = 16'd0;
            tick  = 1'b1;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= 16'd0;
        else      cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_byte_rx.sv
// UART 8N1 byte receiver: synchronizer, start-edge detect, 3-sample majority voter,
// LSB-first shift register and framing check.
module uart_byte_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rs232_rx,
    input  logic [2:0] baud_set,
    output logic [7:0] data_byte,
    output logic       rx_done,
    output logic       frame_err,
    output logic       uart_state
);

    // The divisor table in uart_pkg is precomputed for a 50 MHz clock; CLK_HZ only documents that.
    if (CLK_HZ != 50_000_000) begin : g_nonstandard_clk
    end

    logic        rx_meta_q, rx_meta_d;
    logic        rx_s_q, rx_s_d;
    logic        rx_prev_q, rx_prev_d;
    rx_state_e   state_q, state_d;
    logic [15:0] os_dr_q, os_dr_d;
    logic        tick_dly_q, tick_dly_d;
    logic [3:0]  tick_cnt_q, tick_cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [2:0]  samp_q, samp_d;
    logic        dec_q, dec_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_byte_q, data_byte_d;
    logic        rx_done_q, rx_done_d;
    logic        frame_err_q, frame_err_d;
    logic        uart_state_q, uart_state_d;

    logic tick;
    logic tick_en;
    logic fall;
    logic bit_val;
    logic slot_end;

    assign tick_en  = (state_q != IDLE);
    assign fall     = rx_prev_q & ~rx_s_q;
    assign bit_val  = majority3(samp_q);
    // tick_cnt has already advanced when the delayed tick is seen, so 0 means the 16th tick
    assign slot_end = tick_dly_q && (tick_cnt_q == 4'd0);

    uart_rx_tick_gen u_tick_gen (
        .clk     (clk),
        .rst     (rst),
        .enable  (tick_en),
        .divisor (os_dr_q),
        .tick    (tick)
    );

    // Next-state logic: synchronizer shift, tick/sample bookkeeping and the receive FSM
    always_comb begin
        rx_meta_d   = rs232_rx;
        rx_s_d      = rx_meta_q;
        rx_prev_d   = rx_s_q;
        state_d     = state_q;
        os_dr_d     = os_dr_q;
        tick_dly_d  = tick;
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        samp_d      = samp_q;
        dec_d       = 1'b0;
        shift_d     = shift_q;
        data_byte_d = data_byte_q;
        rx_done_d   = 1'b0;
        frame_err_d = 1'b0;

        if (state_q != IDLE) begin
            if (tick) begin
                tick_cnt_d = (tick_cnt_q == 4'(OVERSAMPLE - 1)) ? 4'd0 : tick_cnt_q + 4'd1;
            end
            if (tick_dly_q) begin
                if (tick_cnt_q == SAMPLE_T0) samp_d[0] = rx_s_q;
                if (tick_cnt_q == SAMPLE_T1) samp_d[1] = rx_s_q;
                if (tick_cnt_q == SAMPLE_T2) begin
                    samp_d[2] = rx_s_q;
                    dec_d     = 1'b1;
                end
            end
        end

        case (state_q)
            IDLE: begin
                if (fall) begin
                    os_dr_d    = os_divisor(baud_set);
                    tick_cnt_d = 4'd0;
                    bit_cnt_d  = 3'd0;
                    state_d    = START;
                end
            end
            START: begin
                if (dec_q && bit_val) begin
                    state_d = IDLE;
                end else if (slot_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (dec_q) begin
                    shift_d = {bit_val, shift_q[7:1]};
                end
                if (slot_end) begin
                    if (bit_cnt_q == 3'(DATA_BITS - 1)) state_d = STOP;
                    else                                 bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end
            STOP: begin
                if (dec_q) begin
                    if (bit_val) begin
                        data_byte_d = shift_q;
                        rx_done_d   = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        uart_state_d = (state_d != IDLE);
    end

    // State and datapath registers; the serial-line flops idle high
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            rx_prev_q    <= 1'b1;
            state_q      <= IDLE;
            os_dr_q      <= 16'd0;
            tick_dly_q   <= 1'b0;
            tick_cnt_q   <= 4'd0;
            bit_cnt_q    <= 3'd0;
            samp_q       <= 3'd0;
            dec_q        <= 1'b0;
            shift_q      <= 8'h00;
            data_byte_q  <= 8'h00;
            rx_done_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            uart_state_q <= 1'b0;
        end else begin
            rx_meta_q    <= rx_meta_d;
            rx_s_q       <= rx_s_d;
            rx_prev_q    <= rx_prev_d;
            state_q      <= state_d;
            os_dr_q      <= os_dr_d;
            tick_dly_q   <= tick_dly_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            samp_q       <= samp_d;
            dec_q        <= dec_d;
            shift_q      <= shift_d;
            data_byte_q  <= data_byte_d;
            rx_done_q    <= rx_done_d;
            frame_err_q  <= frame_err_d;
            uart_state_q <= uart_state_d;
        end
    end

    assign data_byte  = data_byte_q;
    assign rx_done    = rx_done_q;
    assign frame_err  = frame_err_q;
    assign uart_state = uart_state_q;

endmodule

// File: tb/tb_uart_byte_rx.sv
// Testbench for uart_byte_rx: frames are generated from the 8N1 line rules and the
// expected strobe for each frame is queued; a negedge monitor pops and compares.
module tb_uart_byte_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       rs232_rx;
    logic [2:0] baud_set;
    logic [7:0] data_byte;
    logic       rx_done;
    logic       frame_err;
    logic       uart_state;

    uart_byte_rx #(.CLK_HZ(50_000_000)) dut (
        .clk        (clk),
        .rst        (rst),
        .rs232_rx   (rs232_rx),
        .baud_set   (baud_set),
        .data_byte  (data_byte),
        .rx_done    (rx_done),
        .frame_err  (frame_err),
        .uart_state (uart_state)
    );

    always #10 clk = ~clk;

    typedef struct packed {
        logic       is_err;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         os_tab[8];
    int         noise_k[8];
    logic [7:0] last_good;
    logic       prev_done = 1'b0;
    logic       prev_err  = 1'b0;
    int         busy_cnt  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
        end
    endtask

    // Monitor: every strobe must match the oldest queued expectation
    always @(negedge clk) begin
        if (rst) begin
            if (prev_done) chk("rx_done_width", rx_done, 1'b0);
            if (prev_err)  chk("frame_err_width", frame_err, 1'b0);
            if (rx_done || frame_err) begin
                chk("strobe_exclusive", rx_done & frame_err, 1'b0);
                chk("strobe_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    chk("strobe_kind_err", frame_err, mon_e.is_err);
                    chk("data_byte", data_byte, mon_e.data);
                end
            end
        end
        prev_done <= rx_done & rst;
        prev_err  <= frame_err & rst;
        if (uart_state) busy_cnt <= busy_cnt + 1;
    end

    initial begin
        #1_960_000;
        $display("FAIL watchdog: simulation did not complete, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    // Reference model: a good stop yields the byte; a low stop yields an error with the old byte
    task automatic push_exp(input logic [7:0] b, input logic stop_bit);
        exp_t e;
        if (stop_bit) begin
            e.is_err  = 1'b0;
            e.data    = b;
            last_good = b;
        end else begin
            e.is_err = 1'b1;
            e.data   = last_good;
        end
        exp_q.push_back(e);
    endtask

    // Drive one 8N1 frame of p clocks per tick; optional single-sample noise, abort and baud change
    task automatic drive_frame(input logic [7:0] b, input int p, input logic stop_bit,
                               input bit noisy, input int abort_t, input int chg_t,
                               input logic [2:0] chg_val);
        int total;
        total = 160 * p;
        for (int t = 0; t < total; t++) begin
            int   slot;
            int   c;
            logic lvl;
            if (t == abort_t) return;
            slot = t / (16 * p);
            if (slot == 0)      lvl = 1'b0;
            else if (slot <= 8) lvl = b[slot-1];
            else                lvl = stop_bit;
            if (noisy && slot >= 1 && slot <= 8) begin
                c = (16 * slot + noise_k[slot-1]) * p + 2;
                if (t >= c - p / 2 && t <= c + p / 2) lvl = ~lvl;
            end
            if (t == chg_t) baud_set = chg_val;
            @(negedge clk);
            rs232_rx = lvl;
        end
    endtask

    task automatic send(input logic [7:0] b, input logic [2:0] bs, input logic stop_bit, input bit noisy);
        baud_set = bs;
        push_exp(b, stop_bit);
        drive_frame(b, os_tab[bs] + 1, stop_bit, noisy, -1, -1, 3'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rs232_rx = 1'b1;
        end
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk(nm, exp_q.size(), 0);
        chk({nm, "_state_idle"}, uart_state, 1'b0);
    endtask

    initial begin
        logic [7:0] rb;
        logic [2:0] chg;
        int         busy0;
        int         abort_t;

        os_tab    = '{324, 162, 80, 53, 26, 324, 324, 324};
        rst       = 1'b0;
        rs232_rx  = 1'b1;
        baud_set  = 3'd0;
        last_good = 8'h00;

        repeat (5) @(negedge clk);
        chk("rst_data_byte", data_byte, 8'h00);
        chk("rst_rx_done", rx_done, 1'b0);
        chk("rst_frame_err", frame_err, 1'b0);
        chk("rst_uart_state", uart_state, 1'b0);
        rst = 1'b1;
        idle(20);
        chk("post_rst_uart_state", uart_state, 1'b0);

        // 9600 baud, 0x55 with a good stop bit
        send(8'h55, 3'd0, 1'b1, 1'b0);
        idle(40);
        drain("f55");
        chk("f55_data_byte", data_byte, 8'h55);

        // 100-clock glitch at 9600 is a false start
        busy0    = busy_cnt;
        baud_set = 3'd0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            rs232_rx = 1'b0;
        end
        idle(3000);
        chk("glitch_busy_seen", busy_cnt > busy0, 1'b1);
        chk("glitch_state_idle", uart_state, 1'b0);
        chk("glitch_data_byte", data_byte, 8'h55);

        // 0x3C with a low stop bit at 115200
        send(8'h3C, 3'd4, 1'b0, 1'b0);
        idle($urandom_range(80, 20));
        drain("ferr");
        chk("ferr_data_byte", data_byte, 8'h55);

        // Back-to-back frames with no idle gap at 115200
        send(8'hA3, 3'd4, 1'b1, 1'b0);
        send(8'h0F, 3'd4, 1'b1, 1'b0);
        idle($urandom_range(80, 20));
        drain("b2b");
        chk("b2b_data_byte", data_byte, 8'h0F);

        // One corrupted sample out of the three in every data bit
        for (int i = 0; i < 8; i++) noise_k[i] = int'($urandom_range(8, 6));
        send(8'hC6, 3'd4, 1'b1, 1'b1);
        idle($urandom_range(80, 20));
        drain("noise");
        chk("noise_data_byte", data_byte, 8'hC6);

        // Random byte; baud_set switched to a slower code during data bit 2
        rb  = 8'($urandom);
        chg = 3'($urandom_range(3, 0));
        baud_set = 3'd4;
        push_exp(rb, 1'b1);
        drive_frame(rb, 27, 1'b1, 1'b0, -1, 3 * 16 * 27, chg);
        idle($urandom_range(80, 20));
        drain("bchg");
        chk("bchg_data_byte", data_byte, rb);

        // Reset asserted during data bit 4; partial frame must vanish
        baud_set = 3'd4;
        abort_t  = (5 * 16 + int'($urandom_range(12, 2))) * 27;
        drive_frame(8'hE7, 27, 1'b1, 1'b0, abort_t, -1, 3'd0);
        @(negedge clk);
        rst      = 1'b0;
        rs232_rx = 1'b1;
        repeat (2) @(negedge clk);
        chk("midrst_data_byte", data_byte, 8'h00);
        chk("midrst_rx_done", rx_done, 1'b0);
        chk("midrst_frame_err", frame_err, 1'b0);
        chk("midrst_uart_state", uart_state, 1'b0);
        last_good = 8'h00;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        idle(20);
        chk("midrst_queue_empty", exp_q.size(), 0);

        // Clean frame after the reset
        send(8'h81, 3'd4, 1'b1, 1'b0);
        idle($urandom_range(80, 20));
        drain("f81");
        chk("f81_data_byte", data_byte, 8'h81);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
